// File: rtl/pi_cmd_receiver.sv
// pi_cmd_receiver
// Front end between the Raspberry Pi GPIO lines and the dispense controller.
// The raw Pi pins are synchronized, debounced as one 6-bit vector and
// validated. Each filtered candyflag rising edge produces exactly one
// command, offered downstream over a valid/ready handshake.
//
// Ports:
//   clk_x1        12 MHz system clock
//   rst           synchronous reset, active-high
//   teststate_in  raw Pi state select (asynchronous)
//   amount_in     raw Pi dispense amount (asynchronous)
//   candyflag_in  raw Pi dispense request (asynchronous)
//   cmd_ready     downstream can accept a command
//   cmd_valid     command payload valid
//   cmd_state     captured teststate
//   cmd_amount    captured amount
//   cmd_err       one-cycle pulse when a rejected command is detected
//   busy          high whenever the command FSM is not idle
module pi_cmd_receiver #(
    parameter int STABLE_CYCLES = 12000,
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
    input  logic       clk_x1,
    input  logic       rst,
    input  logic [2:0] teststate_in,
    input  logic [1:0] amount_in,
    input  logic       candyflag_in,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_state,
    output logic [1:0] cmd_amount,
    output logic       cmd_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        VALID,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 2);

    // Vector layout: [5:3] teststate, [2:1] amount, [0] candyflag
    logic [5:0]       rawVector;
    logic [5:0]       meta_q;
    logic [5:0]       sync_q;
    logic [5:0]       syncPrev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [5:0]       filt_q;
    logic [5:0]       filt_d;
    logic             flagRise_q;
    logic             flagRise_d;
    logic             stable;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       cmdState_q;
    logic [2:0]       cmdState_d;
    logic [1:0]       cmdAmount_q;
    logic [1:0]       cmdAmount_d;
    logic             cmdErr_q;
    logic             cmdErr_d;

    assign rawVector = {teststate_in, amount_in, candyflag_in};

    // Two-flop synchronizer on every raw pin, plus the one-cycle-old copy
    // of the synced vector that the debouncer compares against.
    always_ff @(posedge clk_x1) begin
        if (rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            syncPrev_q <= '0;
        end else begin
            meta_q     <= rawVector;
            sync_q     <= meta_q;
            syncPrev_q <= sync_q;
        end
    end

    // All six bits are debounced together, so data and flag settling in the
    // same window can never produce a payload mixing old and new values.
    // The filtered vector loads once, as the counter reaches STABLE_CYCLES-1;
    // after saturation the count no longer matches, so there is no reload.
    // flag_rise is registered at the same edge the filtered vector updates,
    // so the FSM sees it alongside the freshly settled payload.
    always_comb begin
        stable     = (sync_q == syncPrev_q);
        cnt_d      = cnt_q;
        filt_d     = filt_q;
        if (!stable) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (stable && (cnt_q == CNT_LOAD)) begin
            filt_d = sync_q;
        end
        flagRise_d = filt_d[0] & ~filt_q[0];
    end

    always_ff @(posedge clk_x1) begin
        if (rst) begin
            cnt_q      <= '0;
            filt_q     <= '0;
            flagRise_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            filt_q     <= filt_d;
            flagRise_q <= flagRise_d;
        end
    end

    // Command FSM. WAIT_LOW is what enforces one command per candyflag pulse:
    // nothing new is accepted until the filtered flag has been seen low.
    // The payload registers only change on an accepted capture, so they keep
    // the last command after transfer and ignore rejected requests.
    always_comb begin
        state_d     = state_q;
        cmdState_d  = cmdState_q;
        cmdAmount_d = cmdAmount_q;
        cmdErr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (flagRise_q) begin
                    if ((filt_q[5:3] != 3'b000) && (filt_q[2:1] != 2'b00)) begin
                        cmdState_d  = filt_q[5:3];
                        cmdAmount_d = filt_q[2:1];
                        state_d     = VALID;
                    end else begin
                        cmdErr_d = 1'b1;
                        state_d  = WAIT_LOW;
                    end
                end
            end
            VALID: begin
                if (cmd_ready) begin
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!filt_q[0]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_x1) begin
        if (rst) begin
            state_q     <= IDLE;
            cmdState_q  <= '0;
            cmdAmount_q <= '0;
            cmdErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmdState_q  <= cmdState_d;
            cmdAmount_q <= cmdAmount_d;
            cmdErr_q    <= cmdErr_d;
        end
    end

    assign cmd_valid  = (state_q == VALID);
    assign busy       = (state_q != IDLE);
    assign cmd_state  = cmdState_q;
    assign cmd_amount = cmdAmount_q;
    assign cmd_err    = cmdErr_q;

endmodule

// File: tb/tb_pi_cmd_receiver.sv
// tb_pi_cmd_receiver
// Directed bench for pi_cmd_receiver with STABLE_CYCLES=4. Inputs are driven
// on the falling clock edge; a monitor counts handshakes, valid cycles and
// error pulses on the rising edge; checks read outputs on the falling edge.
module tb_pi_cmd_receiver;

    logic       clk_x1;
    logic       rst;
    logic [2:0] teststate_in;
    logic [1:0] amount_in;
    logic       candyflag_in;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd_state;
    logic [1:0] cmd_amount;
    logic       cmd_err;
    logic       busy;

    int checkCount;
    int errorCount;

    int         xferCount;
    int         validCycles;
    int         errPulses;
    logic [2:0] xferState;
    logic [1:0] xferAmount;

    int baseXfer;
    int baseValid;
    int baseErr;
    int lat;

    pi_cmd_receiver #(
        .STABLE_CYCLES(4)
    ) dut (
        .clk_x1      (clk_x1),
        .rst         (rst),
        .teststate_in(teststate_in),
        .amount_in   (amount_in),
        .candyflag_in(candyflag_in),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_state   (cmd_state),
        .cmd_amount  (cmd_amount),
        .cmd_err     (cmd_err),
        .busy        (busy)
    );

    initial clk_x1 = 1'b0;
    always #5 clk_x1 = ~clk_x1;

    // Handshake monitor: a transfer is any rising edge with valid and ready.
    always @(posedge clk_x1) begin
        if (cmd_valid) validCycles <= validCycles + 1;
        if (cmd_err) errPulses <= errPulses + 1;
        if (cmd_valid && cmd_ready) begin
            xferCount  <= xferCount + 1;
            xferState  <= cmd_state;
            xferAmount <= cmd_amount;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] ts, input logic [1:0] amt,
                                 input logic flag, input logic rdy);
        teststate_in = ts;
        amount_in    = amt;
        candyflag_in = flag;
        cmd_ready    = rdy;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_x1);
    endtask

    // Waits (bounded) for cmd_valid; lat holds the number of cycles taken.
    task automatic waitValid(input string tag);
        lat = 0;
        while (!cmd_valid && lat < 30) begin
            @(negedge clk_x1);
            lat++;
        end
        checkOutput(tag, int'(cmd_valid), 1);
    endtask

    task automatic snapshot();
        baseXfer  = xferCount;
        baseValid = validCycles;
        baseErr   = errPulses;
    endtask

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        xferCount   = 0;
        validCycles = 0;
        errPulses   = 0;
        xferState   = '0;
        xferAmount  = '0;
        rst = 1'b1;
        applyStimulus(3'b000, 2'b00, 1'b0, 1'b0);
        waitCycles(3);

        // Reset state
        checkOutput("rstValid", int'(cmd_valid), 0);
        checkOutput("rstState", int'(cmd_state), 0);
        checkOutput("rstAmount", int'(cmd_amount), 0);
        checkOutput("rstErr", int'(cmd_err), 0);
        checkOutput("rstBusy", int'(busy), 0);
        rst = 1'b0;
        waitCycles(10);

        // Clean command
        applyStimulus(3'b011, 2'b10, 1'b0, 1'b1);
        waitCycles(10);
        snapshot();
        candyflag_in = 1'b1;
        waitValid("cleanValidSeen");
        checkOutput("cleanLatency6to8", int'(lat >= 6 && lat <= 8), 1);
        checkOutput("cleanState", int'(cmd_state), 3);
        checkOutput("cleanAmount", int'(cmd_amount), 2);
        checkOutput("cleanBusy", int'(busy), 1);
        waitCycles(5);
        checkOutput("cleanXfers", xferCount - baseXfer, 1);
        checkOutput("cleanValidCycles", validCycles - baseValid, 1);
        checkOutput("cleanXferState", int'(xferState), 3);
        checkOutput("cleanXferAmount", int'(xferAmount), 2);
        checkOutput("cleanBusyHeld", int'(busy), 1);
        candyflag_in = 1'b0;
        waitCycles(12);
        checkOutput("cleanBusyReleased", int'(busy), 0);

        // Backpressure, with a teststate change during the wait
        applyStimulus(3'b101, 2'b01, 1'b0, 1'b0);
        waitCycles(10);
        snapshot();
        candyflag_in = 1'b1;
        waitValid("bpValidSeen");
        waitCycles(5);
        teststate_in = 3'b110;
        waitCycles(15);
        checkOutput("bpValidHeld", int'(cmd_valid), 1);
        checkOutput("bpStateHeld", int'(cmd_state), 5);
        checkOutput("bpAmountHeld", int'(cmd_amount), 1);
        checkOutput("bpNoXfer", xferCount - baseXfer, 0);
        cmd_ready = 1'b1;
        waitCycles(3);
        checkOutput("bpOneXfer", xferCount - baseXfer, 1);
        checkOutput("bpValidLong", int'(validCycles - baseValid >= 20), 1);
        checkOutput("bpXferState", int'(xferState), 5);
        checkOutput("bpXferAmount", int'(xferAmount), 1);
        checkOutput("bpPayloadKept", int'(cmd_state), 5);
        checkOutput("bpValidDropped", int'(cmd_valid), 0);
        candyflag_in = 1'b0;
        waitCycles(12);

        // Reject: amount == 00
        applyStimulus(3'b001, 2'b00, 1'b0, 1'b1);
        waitCycles(10);
        snapshot();
        candyflag_in = 1'b1;
        waitCycles(15);
        checkOutput("rejAmtErr", errPulses - baseErr, 1);
        checkOutput("rejAmtNoValid", validCycles - baseValid, 0);
        checkOutput("rejAmtBusy", int'(busy), 1);
        candyflag_in = 1'b0;
        waitCycles(12);
        checkOutput("rejAmtBusyReleased", int'(busy), 0);

        // Reject: teststate == 000
        applyStimulus(3'b000, 2'b01, 1'b0, 1'b1);
        waitCycles(10);
        snapshot();
        candyflag_in = 1'b1;
        waitCycles(15);
        checkOutput("rejTsErr", errPulses - baseErr, 1);
        checkOutput("rejTsNoValid", validCycles - baseValid, 0);
        checkOutput("rejTsBusy", int'(busy), 1);
        checkOutput("rejPayloadKept", int'(cmd_state), 5);
        candyflag_in = 1'b0;
        waitCycles(12);

        // Glitches: 2-cycle flag pulse, then 3-cycle teststate spike
        applyStimulus(3'b011, 2'b10, 1'b0, 1'b1);
        waitCycles(12);
        snapshot();
        candyflag_in = 1'b1;
        waitCycles(2);
        candyflag_in = 1'b0;
        waitCycles(15);
        checkOutput("glitchFlagNoValid", validCycles - baseValid, 0);
        checkOutput("glitchFlagNoErr", errPulses - baseErr, 0);
        checkOutput("glitchFlagFilt", int'(dut.filt_q), 6'b011100);
        teststate_in = 3'b111;
        waitCycles(3);
        teststate_in = 3'b011;
        waitCycles(15);
        checkOutput("glitchTsFilt", int'(dut.filt_q), 6'b011100);
        checkOutput("glitchBusy", int'(busy), 0);

        // Repeat/hold: long high, short low, high again
        snapshot();
        candyflag_in = 1'b1;
        waitCycles(100);
        candyflag_in = 1'b0;
        waitCycles(10);
        candyflag_in = 1'b1;
        waitCycles(30);
        candyflag_in = 1'b0;
        waitCycles(12);
        checkOutput("holdTwoXfers", xferCount - baseXfer, 2);

        // Reset while a command is pending
        applyStimulus(3'b110, 2'b11, 1'b0, 1'b0);
        waitCycles(10);
        snapshot();
        candyflag_in = 1'b1;
        waitValid("rstMidValidSeen");
        rst = 1'b1;
        candyflag_in = 1'b0;
        waitCycles(1);
        rst = 1'b0;
        checkOutput("rstMidValid", int'(cmd_valid), 0);
        checkOutput("rstMidState", int'(cmd_state), 0);
        checkOutput("rstMidAmount", int'(cmd_amount), 0);
        checkOutput("rstMidErr", int'(cmd_err), 0);
        checkOutput("rstMidBusy", int'(busy), 0);
        cmd_ready = 1'b1;
        waitCycles(15);
        checkOutput("rstMidNoXfer", xferCount - baseXfer, 0);
        candyflag_in = 1'b1;
        waitValid("rstMidNewValid");
        waitCycles(3);
        checkOutput("rstMidNewXfer", xferCount - baseXfer, 1);
        checkOutput("rstMidNewState", int'(xferState), 6);
        checkOutput("rstMidNewAmount", int'(xferAmount), 3);
        candyflag_in = 1'b0;
        waitCycles(12);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
